// File: rtl/reply_arbiter.sv
// reply_arbiter: shares the byte-wide UART transmit path among N_SRC reply
//   sources and frames the granted source's message as
//   PREFIX, ADDR_AST, id, len, payload, 8-bit additive checksum.
// Latency: request seen in IDLE at edge k -> PREFIX valid in cycle k+1;
//   each payload byte costs 3 cycles (FETCH, WAIT_Q, SEND_DATA).
// Backpressure: every framed byte is held on tx_data until tx_valid & tx_ready;
//   requests arriving mid-packet wait for the return to IDLE.
// Optional feature: define RR_ARB_EN for round-robin arbitration
//   (default build is fixed priority, lowest index wins).
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   src_req   [N_SRC]     source i holds a complete message
//   src_len   [8*N_SRC]   payload length of source i in bits [8i+7:8i]
//   src_rdreq [N_SRC]     one-hot read strobe to the granted source FIFO
//   src_q     [8*N_SRC]   source read data, valid the cycle after src_rdreq
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   grant     [N_SRC]     one-hot current owner, 0 when idle
//   done                  one-cycle pulse after the checksum byte is accepted

`ifndef N_SRC
`define N_SRC 4
`endif
`ifndef PREFIX
`define PREFIX 8'hAA
`endif
`ifndef ADDR_AST
`define ADDR_AST 8'h2A
`endif

module reply_arbiter #(
  parameter int N_SRC = `N_SRC
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [8*N_SRC-1:0] src_len,
  output logic [N_SRC-1:0]   src_rdreq,
  input  logic [8*N_SRC-1:0] src_q,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               done
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [3:0] {
    IDLE,
    SEND_PREFIX,
    SEND_AST,
    SEND_ID,
    SEND_LEN,
    FETCH,
    WAIT_Q,
    SEND_DATA,
    SEND_CRC
  } state_t;

  state_t        state;
  logic [IW-1:0] win;      // index of the current owner
  logic [IW-1:0] sel;      // arbitration result for the next grant
  logic          any_req;
  logic [7:0]    len;
  logic [7:0]    cnt;      // payload bytes fetched so far
  logic [7:0]    crc;
  logic          hs;
  logic [7:0]    q_byte;
  logic [7:0]    sel_len;
  logic [N_SRC-1:0] sel_oh;
  logic [N_SRC-1:0] win_oh;

  assign hs      = tx_valid & tx_ready;
  assign q_byte  = src_q[{win, 3'b000} +: 8];
  assign sel_len = src_len[{sel, 3'b000} +: 8];
  assign sel_oh  = N_SRC'(1) << sel;
  assign win_oh  = N_SRC'(1) << win;

`ifdef RR_ARB_EN
  // Last winner; the search starts one past it and wraps.
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;

  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N_SRC);
      if (!any_req && src_req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end
`else
  always_comb begin
    sel     = '0;
    any_req = |src_req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) sel = IW'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      win       <= '0;
      len       <= '0;
      cnt       <= '0;
      crc       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      src_rdreq <= '0;
      grant     <= '0;
      done      <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr    <= IW'(N_SRC - 1);
`endif
    end else begin
      done      <= 1'b0;
      src_rdreq <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win      <= sel;
            grant    <= sel_oh;
            len      <= sel_len;
            cnt      <= '0;
            crc      <= '0;
            tx_data  <= `PREFIX;
            tx_valid <= 1'b1;
            state    <= SEND_PREFIX;
`ifdef RR_ARB_EN
            rr_ptr   <= sel;
`endif
          end
        end
        SEND_PREFIX: begin
          if (hs) begin
            tx_data <= `ADDR_AST;
            state   <= SEND_AST;
          end
        end
        SEND_AST: begin
          if (hs) begin
            tx_data <= 8'(win);
            state   <= SEND_ID;
          end
        end
        SEND_ID: begin
          if (hs) begin
            tx_data <= len;
            state   <= SEND_LEN;
          end
        end
        // cnt is 0 leaving SEND_LEN, so cnt < len doubles as len != 0.
        // Comparing before the increment keeps len = 255 from wrapping.
        SEND_LEN, SEND_DATA: begin
          if (hs) begin
            if (cnt < len) begin
              tx_valid  <= 1'b0;
              src_rdreq <= win_oh;
              state     <= FETCH;
            end else begin
              tx_data <= crc;
              state   <= SEND_CRC;
            end
          end
        end
        FETCH: begin
          state <= WAIT_Q;
        end
        WAIT_Q: begin
          tx_data  <= q_byte;
          crc      <= crc + q_byte;
          cnt      <= cnt + 8'd1;
          tx_valid <= 1'b1;
          state    <= SEND_DATA;
        end
        SEND_CRC: begin
          if (hs) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            grant    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reply_arbiter.sv
// tb_reply_arbiter: packet table plus arbitration and reset sequences for
//   reply_arbiter with N_SRC = 4; expected bytes are queued when a request
//   is issued and popped on each tx_valid & tx_ready handshake.

`ifndef PREFIX
`define PREFIX 8'hAA
`endif
`ifndef ADDR_AST
`define ADDR_AST 8'h2A
`endif

module tb_reply_arbiter;
  localparam int N = 4;
  localparam logic [7:0] PFX = `PREFIX;
  localparam logic [7:0] AST = `ADDR_AST;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [N-1:0]   src_req;
  logic [8*N-1:0] src_len;
  logic [N-1:0]   src_rdreq;
  logic [8*N-1:0] src_q = '0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           done;

  reply_arbiter #(.N_SRC(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .src_req   (src_req),
    .src_len   (src_len),
    .src_rdreq (src_rdreq),
    .src_q     (src_q),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .done      (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo [N][$];
  int         rd_cnt [N] = '{default: 0};
  logic [7:0] exp_q [$];
  int         done_total = 0;
  bit         bp = 1'b0;
  int         ph = 0;
  logic       held = 1'b0;
  logic [7:0] held_dat = '0;

  typedef struct {
    int          src;
    int          len;
    bit          ramp;   // payload byte j = j instead of d
    logic [31:0] d;      // payload byte j in d[8j+7:8j]
    bit          bp;
    logic [7:0]  crc;
    int          cyc;    // expected cycles with grant set, 0 = not checked
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Source FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (src_rdreq[i]) begin
        rd_cnt[i]++;
        if (fifo[i].size() > 0) src_q[8*i +: 8] <= fifo[i].pop_front();
        else fail($sformatf("underflow_src%0d", i), 32'(i));
      end
    end
  end

  // Transmitter: 1 cycle ready / 3 cycles not ready when bp is set.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        tx_ready = (ph == 0);
        ph = (ph + 1) % 4;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard and hold monitor.
  always @(negedge clk) begin
    if (n_rst) begin
      if (held) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(held_dat));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail("tx_extra_byte", 32'(tx_data));
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done) done_total++;
    end
    held     = n_rst && tx_valid && !tx_ready;
    held_dat = tx_data;
  end

  task automatic run_packet(input vec_t v, input string tag);
    int cyc, guard, d0, r0;
    logic [7:0] b;
    logic [N-1:0] oh;
    bp = v.bp;
    exp_q.push_back(PFX);
    exp_q.push_back(AST);
    exp_q.push_back(8'(v.src));
    exp_q.push_back(8'(v.len));
    for (int j = 0; j < v.len; j++) begin
      if (v.ramp) b = 8'(j);
      else b = v.d[8*j +: 8];
      fifo[v.src].push_back(b);
      exp_q.push_back(b);
    end
    exp_q.push_back(v.crc);
    oh = '0;
    oh[v.src] = 1'b1;
    src_len[8*v.src +: 8] = 8'(v.len);
    d0 = done_total;
    r0 = rd_cnt[v.src];
    src_req[v.src] = 1'b1;
    @(negedge clk);
    check({tag, "_first_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_first_prefix"}, 32'(tx_data), 32'(PFX));
    check({tag, "_grant"}, 32'(grant), 32'(oh));
    src_req[v.src] = 1'b0;
    cyc = 1;
    guard = 0;
    while (!done && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (grant != 0) cyc++;
    end
    if (!done) fail({tag, "_timeout_done"}, 32'(guard));
    @(negedge clk);
    @(negedge clk);
    bp = 1'b0;
    check({tag, "_done_pulses"}, 32'(done_total - d0), 32'd1);
    check({tag, "_reads"}, 32'(rd_cnt[v.src] - r0), 32'(v.len));
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    if (v.cyc != 0) check({tag, "_cycles"}, 32'(cyc), 32'(v.cyc));
  endtask

  task automatic run_arb();
    logic [N-1:0] exp_g [$];
    logic [N-1:0] prev;
    int n, k, guard, id, rd0;
`ifdef RR_ARB_EN
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001};
`endif
    foreach (exp_g[e]) begin
      id = 0;
      for (int b = 0; b < N; b++) if (exp_g[e][b]) id = b;
      exp_q.push_back(PFX);
      exp_q.push_back(AST);
      exp_q.push_back(8'(id));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
    end
    rd0 = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    src_len = '0;
    src_req = 4'b1011;
    prev = grant;
    n = 0;
    k = 0;
    guard = 0;
    while (n < exp_g.size() && guard < 500) begin
      @(negedge clk);
      guard++;
      if (grant != 0 && prev == 0) begin
        if (k < exp_g.size()) check($sformatf("arb_grant%0d", k), 32'(grant), 32'(exp_g[k]));
        else fail("arb_extra_grant", 32'(grant));
        k++;
      end
      prev = grant;
      if (done) n++;
    end
    src_req = '0;
    check("arb_packets", 32'(n), 32'(exp_g.size()));
    repeat (3) @(negedge clk);
    check("arb_idle_grant", 32'(grant), 32'd0);
    check("arb_bytes_left", 32'(exp_q.size()), 32'd0);
    check("arb_no_reads", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - rd0), 32'd0);
  endtask

  task automatic run_reset();
    int guard;
    vec_t v;
    bp = 1'b0;
    fifo[1].push_back(8'h11);
    fifo[1].push_back(8'h22);
    fifo[1].push_back(8'h33);
    exp_q.push_back(PFX);
    exp_q.push_back(AST);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    src_len[15:8] = 8'd3;
    src_req[1] = 1'b1;
    guard = 0;
    while (!(tx_valid && tx_data == 8'h22 && grant == 4'b0010) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (grant != 0) src_req[1] = 1'b0;
    end
    check("rst_reached_byte2", 32'(tx_data), 32'h22);
    #1;
    n_rst = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rdreq", 32'(src_rdreq), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    src_req = '0;
    exp_q.delete();
    fifo[1].delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    // 0x44 checksum only holds if the partial sum 0x33 was cleared.
    v = '{src: 1, len: 1, ramp: 1'b0, d: 32'h00000044, bp: 1'b0, crc: 8'h44, cyc: 8};
    run_packet(v, "post_rst");
  endtask

  initial begin
    n_rst   = 1'b0;
    src_req = '0;
    src_len = '0;
    repeat (2) @(negedge clk);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rdreq", 32'(src_rdreq), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_tx_valid", 32'(tx_valid), 32'd0);

    tbl[0] = '{src: 2, len: 3,   ramp: 1'b0, d: 32'h00302010, bp: 1'b0, crc: 8'h60, cyc: 14};
    tbl[1] = '{src: 1, len: 2,   ramp: 1'b0, d: 32'h000002FF, bp: 1'b0, crc: 8'h01, cyc: 11};
    tbl[2] = '{src: 0, len: 0,   ramp: 1'b0, d: 32'h00000000, bp: 1'b0, crc: 8'h00, cyc: 5};
    tbl[3] = '{src: 3, len: 3,   ramp: 1'b0, d: 32'h00302010, bp: 1'b1, crc: 8'h60, cyc: 0};
    tbl[4] = '{src: 2, len: 4,   ramp: 1'b0, d: 32'hFA030201, bp: 1'b1, crc: 8'h00, cyc: 0};
    tbl[5] = '{src: 3, len: 255, ramp: 1'b1, d: 32'h00000000, bp: 1'b0, crc: 8'h81, cyc: 770};

    for (int i = 0; i < 6; i++) run_packet(tbl[i], $sformatf("pkt%0d", i));

    run_arb();
    run_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reply_arbiter.md
# reply_arbiter

Shares the single byte-wide UART transmit path among `N_SRC` reply sources (the same peripherals the command decoder addresses through its one-hot `valid_bus`). It grants one source at a time and frames its pending message in the same packet format the decoder accepts: PREFIX, ADDR_AST, source id, length, payload, 8-bit additive checksum. It sits between the peripheral reply FIFOs and the UART transmitter.

## Interface
Parameters:
- `N_SRC`, default `` `N_SRC ``, number of reply sources (1..256).

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `src_req`  in  N_SRC  source i holds a complete message; stays high until granted.
- `src_len`  in  8*N_SRC  payload length of source i in bits [8i+7:8i]; stable while `src_req[i]` is high.
- `src_rdreq`  out  N_SRC  one-hot read strobe to the granted source FIFO.
- `src_q`  in  8*N_SRC  source i read data; valid the cycle after its `src_rdreq`.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte when high together with `tx_valid`.
- `grant`  out  N_SRC  one-hot current owner, 0 when idle.
- `done`  out  1  one-cycle pulse when the CRC byte is accepted.

## Operation
- States: IDLE, SEND_PREFIX, SEND_AST, SEND_ID, SEND_LEN, FETCH, WAIT_Q, SEND_DATA, SEND_CRC.
- IDLE: if any `src_req` is set, select winner, register `grant`, latch `len`, clear `cnt` and `crc`, go to SEND_PREFIX.
- SEND_PREFIX/AST/ID/LEN: drive `` `PREFIX ``, `` `ADDR_AST ``, winner index (8 bits, zero-extended), `len`. Advance only on `tx_valid & tx_ready`.
- After SEND_LEN: go to FETCH if `len != 0`, else to SEND_CRC.
- FETCH: `src_rdreq[winner]` = 1 for exactly this cycle. Go to WAIT_Q.
- WAIT_Q: capture the winner's `src_q` slice into `tx_data`, set `crc <= crc + byte` (mod 256), `cnt <= cnt + 1`. Go to SEND_DATA.
- SEND_DATA: on handshake, go to FETCH if `cnt < len`, else to SEND_CRC.
- SEND_CRC: drive `crc`. On handshake, pulse `done`, clear `grant`, return to IDLE.
- `src_req` of the owner is ignored from grant to IDLE. Requests arriving mid-packet wait.
- `src_rdreq` is never asserted outside FETCH, and never more than `len` times per packet.
- The arbiter does not check for source underflow. The source guarantees `len` bytes are available.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `src_rdreq`=0, `grant`=0, `done`=0. State=IDLE, `cnt`=0, `crc`=0. The RR pointer is `N_SRC-1`, so source 0 wins first.
- Request-to-first-byte: `src_req` high in IDLE at edge k gives `tx_valid`/PREFIX in cycle k+1.
- `tx_valid` is registered and high in every SEND_* state. `tx_data` is stable while `tx_valid & !tx_ready`.
- Payload: 3 cycles per byte minimum (FETCH, WAIT_Q, SEND_DATA with `tx_ready`=1).
- Packet with `tx_ready` held at 1: 4 + 3·len + 1 cycles, plus 1 IDLE cycle before the next grant.
- `len`=255 is legal. `cnt` is 8-bit and compares before increment, so no wrap occurs.
- Async reset mid-packet drops the packet immediately; all outputs take their reset values. The source FIFO keeps any unread bytes, and clearing it is the source's responsibility.

## Configuration
- `RR_ARB_EN` defined: round-robin arbitration. The search starts at (last winner + 1) mod `N_SRC` and wraps. The pointer updates at each grant.
- `RR_ARB_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Single packet: source 2 with `len`=3 and data 0x10,0x20,0x30, `tx_ready`=1 → `tx_data` stream PREFIX, ADDR_AST, 0x02, 0x03, 0x10, 0x20, 0x30, 0x60. Exactly 3 `src_rdreq[2]` pulses; `done` pulses once; packet takes 14 cycles.
- Checksum wrap: `len`=2, data 0xFF, 0x02 → CRC byte 0x01.
- Zero length: source 0 with `len`=0 → PREFIX, ADDR_AST, 0x00, 0x00, 0x00; no `src_rdreq` pulse.
- Backpressure: `tx_ready` toggles 1 cycle high / 3 cycles low → every byte is held stable until accepted, the stream is unchanged, and there are no extra reads.
- Arbitration: `src_req`=4'b1011 held, with `N_SRC`=4.
  - `RR_ARB_EN` defined: grant order 0, 1, 3, 0.
  - Undefined: grant order 0, 0, 0 while bit 0 stays high.
- Reset mid-packet: assert `n_rst`=0 during the second payload byte → `tx_valid`, `grant` and `src_rdreq` go to 0 asynchronously. After release, the next request restarts from PREFIX with `crc`=0.
